// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit 0 is fetch, bit 1 is data.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // last=1 means the data port was served most recently, so fetch wins a tie.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one instruction/data memory between the fetch and load/store ports,
// running each access over a fixed number of memory cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    arb_state_t        state;
    logic              owner;
    logic              last_d;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_err_q;
    logic              d_err_q;

    logic [1:0]        pick;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_misaligned;

    rr_arb2 u_rr (
        .req  ({d_req, if_req}),
        .last (last_d),
        .gnt  (pick)
    );

    // Grants are held off during reset so every output reads 0 while rst=0.
    assign grant          = (state == ST_IDLE && rst) ? pick : 2'b00;
    assign sel_addr       = grant[1] ? d_addr : if_addr;
    assign sel_misaligned = is_misaligned(sel_addr[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            last_d     <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        owner     <= grant[1] ? OWN_D : OWN_IF;
                        last_d    <= grant[1];
                        lat_addr  <= sel_addr;
                        lat_we    <= grant[1] & d_we;
                        lat_wdata <= grant[1] ? d_wdata : '0;
                        cnt       <= CNT_INIT;
                        if (sel_misaligned) begin
                            state <= ST_RESP;
                            if (grant[1]) begin
                                d_err_q   <= 1'b1;
                                d_rdata_q <= '0;
                            end else begin
                                if_err_q   <= 1'b1;
                                if_rdata_q <= '0;
                            end
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                        if (owner == OWN_D) begin
                            d_err_q   <= 1'b0;
                            d_rdata_q <= lat_we ? '0 : mem_out;
                        end else begin
                            if_err_q   <= 1'b0;
                            if_rdata_q <= mem_out;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = grant[0];
    assign d_gnt     = grant[1];
    assign if_rvalid = (state == ST_RESP) && (owner == OWN_IF);
    assign d_rvalid  = (state == ST_RESP) && (owner == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_err    = if_err_q;
    assign d_err     = d_err_q;
    assign mem_a     = lat_addr;
    assign mem_wd    = lat_wdata;
    assign mem_we    = (state == ST_ACCESS) && (cnt == 4'd0) && lat_we;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=2 main instance plus MEM_LAT=1/15 instances.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_out;
    logic        busy;

    logic        s1_req, s1_gnt, s1_rvalid, s1_err, s1_if_gnt, s1_if_rvalid, s1_if_err, s1_mem_we, s1_busy;
    logic [31:0] s1_rdata, s1_if_rdata, s1_mem_wd;
    logic [15:0] s1_mem_a;
    logic        s15_req, s15_gnt, s15_rvalid, s15_err, s15_if_gnt, s15_if_rvalid, s15_if_err, s15_mem_we, s15_busy;
    logic [31:0] s15_rdata, s15_if_rdata, s15_mem_wd;
    logic [15:0] s15_mem_a;

    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int errors;
    int checks;

    mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_out(mem_out), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(16'h0000), .if_gnt(s1_if_gnt), .if_rvalid(s1_if_rvalid),
        .if_rdata(s1_if_rdata), .if_err(s1_if_err),
        .d_req(s1_req), .d_we(1'b0), .d_addr(16'h0004), .d_wdata(32'h0), .d_gnt(s1_gnt),
        .d_rvalid(s1_rvalid), .d_rdata(s1_rdata), .d_err(s1_err),
        .mem_a(s1_mem_a), .mem_we(s1_mem_we), .mem_wd(s1_mem_wd), .mem_out(32'h1111_0001),
        .busy(s1_busy)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(15)) dut_lat15 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(16'h0000), .if_gnt(s15_if_gnt), .if_rvalid(s15_if_rvalid),
        .if_rdata(s15_if_rdata), .if_err(s15_if_err),
        .d_req(s15_req), .d_we(1'b0), .d_addr(16'h0004), .d_wdata(32'h0), .d_gnt(s15_gnt),
        .d_rvalid(s15_rvalid), .d_rdata(s15_rdata), .d_err(s15_err),
        .mem_a(s15_mem_a), .mem_we(s15_mem_we), .mem_wd(s15_mem_wd), .mem_out(32'h1515_0015),
        .busy(s15_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read, synchronous-write memory; preload shares the write port.
    assign mem_out = mem[mem_a[9:2]];
    always @(posedge clk) begin
        if (mem_we)
            mem[mem_a[9:2]] <= mem_wd;
        else if (pl_en)
            mem[pl_idx] <= pl_data;
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic run_txn(input logic is_d, input logic we, input logic [15:0] addr,
                           input logic [31:0] wdata, output int gnt_c, output int rv_c,
                           output int we_cnt, output int we_c, output int busy_cnt,
                           output logic [15:0] we_addr, output logic [31:0] rdata,
                           output logic err, output logic other_rv);
        logic granted;
        gnt_c = -1; rv_c = -1; we_cnt = 0; we_c = -1; busy_cnt = 0;
        we_addr = '0; rdata = '0; err = 1'b0; other_rv = 1'b0; granted = 1'b0;
        @(posedge clk);
        #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!granted && (is_d ? d_gnt : if_gnt)) begin
                granted = 1'b1;
                gnt_c   = c;
            end
            if (busy) busy_cnt++;
            if (mem_we) begin
                we_cnt++;
                we_c    = c;
                we_addr = mem_a;
            end
            if (is_d ? if_rvalid : d_rvalid) other_rv = 1'b1;
            if (rv_c < 0 && (is_d ? d_rvalid : if_rvalid)) begin
                rv_c  = c;
                rdata = is_d ? d_rdata : if_rdata;
                err   = is_d ? d_err : if_err;
            end
            @(posedge clk);
            #1;
            if (granted) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            if (rv_c >= 0) break;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 00", {if_rvalid, d_rvalid}); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_rdata: got %h want 0", if_rdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_d_rdata: got %h want 0", d_rdata); end
        checks++; if (mem_a !== 16'h0) begin errors++; $display("[TB] FAIL reset_mem_a: got %h want 0", mem_a); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("[TB] FAIL drop_store_gnt: got %b want 1", d_gnt); end
        @(posedge clk);
        #1;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        checks++; if ({busy, mem_we} !== 2'b10) begin errors++; $display("[TB] FAIL drop_store_c1: busy,we got %b want 10", {busy, mem_we}); end
        @(posedge clk);
        #1;
        checks++; if ({mem_we, mem_a} !== {1'b1, 16'h0020}) begin errors++; $display("[TB] FAIL drop_store_c2_we: got %b/%h want 1/0020", mem_we, mem_a); end
        rst = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_mem_we: got %b want 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        checks++; if (mem[8] !== 32'h5555_AAAA) begin errors++; $display("[TB] FAIL dropped_store_write: mem got %h want 5555aaaa", mem[8]); end
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || d_rvalid || if_rvalid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL dropped_store_response: activity got %b want 0", seen); end
    endtask

    task automatic test_single_load();
        int g, rv, wc, wcy, bc;
        logic [15:0] wa;
        logic [31:0] rd;
        logic er, orv;
        run_txn(1'b1, 1'b0, 16'h0040, 32'h0, g, rv, wc, wcy, bc, wa, rd, er, orv);
        checks++; if (g !== 0) begin errors++; $display("[TB] FAIL load_gnt_cycle: got %0d want 0", g); end
        checks++; if (rv !== 3) begin errors++; $display("[TB] FAIL load_rvalid_cycle: got %0d want 3", rv); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_rdata: got %h want deadbeef", rd); end
        checks++; if ({er, orv} !== 2'b00) begin errors++; $display("[TB] FAIL load_err_if_rvalid: got %b want 00", {er, orv}); end
        checks++; if ({wc, bc} !== {32'd0, 32'd3}) begin errors++; $display("[TB] FAIL load_we_busy: we=%0d busy=%0d want 0/3", wc, bc); end
        run_txn(1'b0, 1'b0, 16'h0040, 32'h0, g, rv, wc, wcy, bc, wa, rd, er, orv);
        checks++; if ({rv, rd} !== {32'd3, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL fetch_0x40: cycle %0d data %h want 3/deadbeef", rv, rd); end
        checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL d_rdata_hold: got %h want deadbeef", d_rdata); end
    endtask

    task automatic test_misaligned();
        int g, rv, wc, wcy, bc;
        logic [15:0] wa;
        logic [31:0] rd;
        logic er, orv;
        run_txn(1'b1, 1'b0, 16'h0042, 32'h0, g, rv, wc, wcy, bc, wa, rd, er, orv);
        checks++; if ({g, rv} !== {32'd0, 32'd1}) begin errors++; $display("[TB] FAIL misalign_load_timing: gnt %0d rvalid %0d want 0/1", g, rv); end
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL misalign_load_resp: err %b data %h want 1/0", er, rd); end
        checks++; if ({wc, bc} !== {32'd0, 32'd1}) begin errors++; $display("[TB] FAIL misalign_load_we_busy: we=%0d busy=%0d want 0/1", wc, bc); end
        checks++; if (if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL if_rdata_hold: got %h want deadbeef", if_rdata); end
        run_txn(1'b1, 1'b1, 16'h0043, 32'hFFFF_FFFF, g, rv, wc, wcy, bc, wa, rd, er, orv);
        checks++; if ({wc, rv, er} !== {32'd0, 32'd1, 1'b1}) begin errors++; $display("[TB] FAIL misalign_store: we=%0d rvalid=%0d err=%b want 0/1/1", wc, rv, er); end
    endtask

    task automatic test_store_fetch();
        int g, rv, wc, wcy, bc;
        logic [15:0] wa;
        logic [31:0] rd;
        logic er, orv;
        run_txn(1'b1, 1'b1, 16'h0010, 32'h1234_5678, g, rv, wc, wcy, bc, wa, rd, er, orv);
        checks++; if ({wc, wcy} !== {32'd1, 32'd2}) begin errors++; $display("[TB] FAIL store_we_pulse: count %0d cycle %0d want 1/2", wc, wcy); end
        checks++; if (wa !== 16'h0010) begin errors++; $display("[TB] FAIL store_mem_a: got %h want 0010", wa); end
        checks++; if ({rv, rd, er} !== {32'd3, 32'h0, 1'b0}) begin errors++; $display("[TB] FAIL store_resp: cycle %0d data %h err %b want 3/0/0", rv, rd, er); end
        run_txn(1'b0, 1'b0, 16'h0010, 32'h0, g, rv, wc, wcy, bc, wa, rd, er, orv);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("[TB] FAIL fetch_after_store: got %h want 12345678", rd); end
        checks++; if ({g, rv, er, orv} !== {32'd0, 32'd3, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL fetch_timing: gnt %0d rvalid %0d err %b d_rvalid %b", g, rv, er, orv); end
    endtask

    task automatic test_contention();
        int   gc [0:7];
        logic gw [0:7];
        int   n;
        logic both;
        n = 0;
        both = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(negedge clk);
        checks++; if ({if_gnt, d_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL gnt_in_reset: got %b want 00", {if_gnt, d_gnt}); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) both = 1'b1;
            if ((if_gnt || d_gnt) && n < 8) begin
                gc[n] = c;
                gw[n] = d_gnt;
                n++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        checks++; if ({both, n} !== {1'b0, 32'd5}) begin errors++; $display("[TB] FAIL contention_count: both=%b grants=%0d want 0/5", both, n); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k < n && (gc[k] !== 4 * k || gw[k] !== k[0])) begin
                errors++;
                $display("[TB] FAIL contention_grant%0d: cycle %0d port %b want %0d/%b", k, gc[k], gw[k], 4 * k, k[0]);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_latency_sweep();
        int   rv1, rv15, b1, b15;
        logic g1, g15, stray1, stray15;
        logic [31:0] rd1, rd15;
        logic [15:0] a1, a15;
        logic e1, e15;
        rv1 = -1; rv15 = -1; b1 = 0; b15 = 0; g1 = 1'b0; g15 = 1'b0;
        stray1 = 1'b0; stray15 = 1'b0; rd1 = '0; rd15 = '0; a1 = '0; a15 = '0; e1 = 1'b1; e15 = 1'b1;
        @(posedge clk);
        #1;
        s1_req = 1'b1;
        s15_req = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c == 0) begin
                g1  = s1_gnt;
                g15 = s15_gnt;
            end
            if (s1_busy) b1++;
            if (s15_busy) b15++;
            if (s1_if_gnt || s1_if_rvalid || s1_if_err || s1_mem_we || s1_if_rdata != 0 || s1_mem_wd != 0) stray1 = 1'b1;
            if (s15_if_gnt || s15_if_rvalid || s15_if_err || s15_mem_we || s15_if_rdata != 0 || s15_mem_wd != 0) stray15 = 1'b1;
            if (rv1 < 0 && s1_rvalid) begin rv1 = c; rd1 = s1_rdata; a1 = s1_mem_a; e1 = s1_err; end
            if (rv15 < 0 && s15_rvalid) begin rv15 = c; rd15 = s15_rdata; a15 = s15_mem_a; e15 = s15_err; end
            @(posedge clk);
            #1;
            s1_req  = 1'b0;
            s15_req = 1'b0;
        end
        checks++; if ({g1, g15} !== 2'b11) begin errors++; $display("[TB] FAIL sweep_gnt: got %b want 11", {g1, g15}); end
        checks++; if ({rv1, b1} !== {32'd2, 32'd2}) begin errors++; $display("[TB] FAIL lat1_timing: rvalid %0d busy %0d want 2/2", rv1, b1); end
        checks++; if ({rv15, b15} !== {32'd16, 32'd16}) begin errors++; $display("[TB] FAIL lat15_timing: rvalid %0d busy %0d want 16/16", rv15, b15); end
        checks++; if ({rd1, a1, e1} !== {32'h1111_0001, 16'h0004, 1'b0}) begin errors++; $display("[TB] FAIL lat1_resp: data %h addr %h err %b", rd1, a1, e1); end
        checks++; if ({rd15, a15, e15} !== {32'h1515_0015, 16'h0004, 1'b0}) begin errors++; $display("[TB] FAIL lat15_resp: data %h addr %h err %b", rd15, a15, e15); end
        checks++; if ({stray1, stray15} !== 2'b00) begin errors++; $display("[TB] FAIL sweep_stray_activity: got %b want 00", {stray1, stray15}); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        s1_req = 1'b0; s15_req = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        preload(8'd8, 32'h5555_AAAA);
        preload(8'd16, 32'hDEAD_BEEF);
        $display("[TB] starting mem_arbiter directed tests");
        test_reset();
        test_single_load();
        test_misaligned();
        test_store_fetch();
        test_contention();
        test_latency_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory of the multicycle RISC-V core between two requesters: the instruction-fetch port (IF) and the load/store port (D).
- Sequences each access over a fixed number of memory cycles, then returns read data with a one-cycle valid pulse.
- Sits between the core's multicycle controller/datapath and the shared memory block, and owns the memory's address, write-enable and write-data inputs.

Parameters:
- ADDR_W, 16, byte-address width presented to memory.
- DATA_W, 32, data word width.
- MEM_LAT, 2, memory cycles per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low; the block is in reset while rst=0.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: fetch response is on if_rdata/if_err.
- if_rdata  out  DATA_W  fetch read data.
- if_err  out  1  misaligned fetch; qualified by if_rvalid.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DATA_W/1  same meaning as the IF equivalents.
- mem_a  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wd  out  DATA_W  memory write data.
- mem_out  in  DATA_W  memory read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States:
  - IDLE: accepts a request.
  - ACCESS: drives memory.
  - RESP: returns the response.
  - All three transitions are on the rising edge of clk.
- Reset (rst=0, asynchronous, may occur mid-operation):
  - Next state is IDLE and any in-flight transaction is dropped.
  - All outputs go to 0 immediately: mem_we is deasserted without waiting for a clock.
  - The round-robin pointer last_d is set to 1, so IF wins the first conflict.
  - Internal address, data and counter registers are cleared to 0.
- Grant:
  - if_gnt/d_gnt are combinational and may assert only in IDLE.
  - If exactly one request is present, that requester is granted.
  - If both are present, the requester not served last is granted, and last_d is updated on the grant.
  - At most one gnt is high in any cycle.
  - On the grant edge the block latches owner, address, we and wdata.
- Misalignment: if the latched address has addr[1:0] != 0, the block goes IDLE -> RESP with no memory access. The owner's err=1 and rdata=0. mem_we is never asserted.
- ACCESS:
  - mem_a holds the latched address.
  - mem_wd holds the latched wdata.
  - The counter loads MEM_LAT-1 and decrements each cycle.
  - At count 0:
    - Stores: mem_we=1 for exactly this one cycle.
    - Loads: mem_out is captured into the owner's rdata register.
    - Stores: the owner's rdata register is set to 0.
  - Next state is RESP.
- RESP:
  - The owner's rvalid=1 for one cycle, with err as set above.
  - The block returns to IDLE; no grant is issued in the RESP cycle.
- rdata hold: if_rdata and d_rdata each hold their value until the next response to that same port.
- Latency: with the grant in cycle 0, rvalid asserts in cycle MEM_LAT+1. A misaligned request responds in cycle 1.
- Back-to-back: a new grant is possible in the cycle after RESP. Sustained throughput is one access per MEM_LAT+2 cycles.
- Request drop: a request deasserted before its grant is simply not served. Requests asserted outside IDLE wait.
- Output ownership: mem_a/mem_wd outside ACCESS hold their last values; only mem_we is significant to memory.

Decomposition:
- Shared package (mem_arb_pkg):
  - State enum ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2.
  - Owner encoding OWN_IF=1'b0, OWN_D=1'b1.
  - Constant WORD_ALIGN_MASK=2'b11.
- Sub-module: rr_arb2, a combinational two-way round-robin picker with inputs req[1:0] and last, and a one-hot grant output. The FSM, counter and response registers stay in mem_arbiter.

Test Plan:
- Reset: assert rst=0 mid-ACCESS of a store -> mem_we=0 immediately; after release, busy=0 and no rvalid ever appears for the dropped store.
- Single load, MEM_LAT=2: memory word 0x40 = 0xDEADBEEF; d_req with d_addr=0x0040 in cycle 0 -> d_gnt in cycle 0, d_rvalid and d_rdata=0xDEADBEEF in cycle 3, if_rvalid stays 0.
- Store then fetch: store 0x12345678 to address 0x0010 -> mem_we high for exactly one cycle (cycle 2) with mem_a=0x0010; then if_addr=0x0010 -> if_rdata=0x12345678.
- Contention: if_req and d_req both held high continuously from reset release -> grants alternate IF, D, IF, D, each 4 cycles apart.
- Misaligned access: d_addr=0x0042, load -> d_gnt in cycle 0, d_rvalid with d_err=1 and d_rdata=0 in cycle 1; mem_we never asserted.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 -> rvalid arrives exactly at cycle MEM_LAT+1, and busy is high for exactly MEM_LAT+1 cycles.
